rr_grant_scheduler: RTL and testbench
=====================================

Name: rr_grant_scheduler

Overview:
Round-robin scheduler that shares one resource among 2**SELECT_WIDTH requesters, such as a shared write port or a bus slot in the pipelined datapath. It registers the winning requester index and drives a one-hot grant vector by decoding that index. A grant is held until the owner asserts done, the owner drops its request, or an optional hold-timeout counter expires. Priority then rotates to the requester after the last owner.

Parameters:
SELECT_WIDTH, 3, width of the grant index; number of requesters N = 2**SELECT_WIDTH.
MAX_HOLD, 16, maximum cycles a grant may be held; 0 disables the timeout.
HOLD_WIDTH, 5, width of the hold counter; must satisfy 2**HOLD_WIDTH > MAX_HOLD.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
req  input  N  request vector; bit i = requester i wants the resource.
done  input  1  current owner releases the resource this cycle.
grant  output  N  one-hot grant; all zero when no owner.
grant_idx  output  SELECT_WIDTH  index of the current owner; valid only when grant_valid=1.
grant_valid  output  1  a grant is active.
timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: state=IDLE, grant=0, grant_idx=0, grant_valid=0, timeout=0, rotation pointer ptr=0, hold counter=0.
- Reset mid-grant: the grant drops on the next edge; no timeout pulse.
- State IDLE:
  - If req is non-zero, select the first set bit searching ptr, ptr+1, ... N-1, 0, ... ptr-1 (modulo N).
  - Register that index into grant_idx, set grant_valid=1, clear the hold counter, go to GRANT.
  - Latency: req asserted in cycle t gives grant visible in cycle t+1.
- State GRANT: increment the hold counter each cycle. Release conditions are checked in priority order:
  - 1. done=1.
  - 2. req[grant_idx]=0, an implicit release.
  - 3. MAX_HOLD!=0 and counter == MAX_HOLD-1, which also pulses timeout=1 in the following cycle.
- On release:
  - Set ptr = grant_idx+1 (mod N, natural wrap at SELECT_WIDTH bits).
  - In the same cycle, run the IDLE search with the new ptr, masking out the releasing requester.
  - If another requester is found, grant it back-to-back on the next edge and stay in GRANT, with the counter cleared.
  - Otherwise go to IDLE with grant_valid=0.
  - The releasing requester is eligible again only after one cycle or when it is the sole requester. The sole-requester case goes through IDLE, giving one bubble cycle.
- grant = grant_valid ? (1 << grant_idx) : 0. This is a combinational decode of the registered index, so grant is glitch-free relative to clk.
- done asserted while grant_valid=0 is ignored.
- New requests arriving during GRANT never preempt the owner.
- Starvation bound: every continuously requesting requester is granted within N-1 other grants.

Decomposition:
- Shared package/header: state encoding constants ST_IDLE and ST_GRANT.
- The helper function or localparam for N.
- One natural sub-module: grant decode through the existing nbit_demux, with DeMuxIn=grant_valid, DeMuxSel=grant_idx, DeMuxOut=grant.
- The rotating priority search is a combinational block inside rr_grant_scheduler.

Test Plan:
- Reset: hold reset=1 for 2 cycles with req=8'hFF -> grant=0, grant_valid=0, timeout=0; after release, grant=8'h01 one cycle later (ptr=0).
- Rotation: req=8'hFF held, done pulsed each grant cycle -> grant_idx sequence 0,1,2,...,7,0 with no bubble cycles.
- Skip and wrap: after requester 6 released, req=8'h05 -> grant_idx=0; then with ptr=1 and req=8'h05 -> grant_idx=2.
- Timeout: MAX_HOLD=4, req=8'h0A, done=0 -> requester 1 granted 4 cycles, timeout pulses 1 cycle, then grant=8'h08.
- Implicit release / sole requester: req=8'h10 granted, req drops to 0 -> grant_valid=0 next cycle. Then with req=8'h10 held and done pulsed -> one bubble cycle, then grant=8'h10 again.
- Reset mid-grant: requester 3 owning with counter=2, assert reset -> grant=0 and ptr=0 next edge; after reset with req=8'h88 -> grant_idx=3.

Source files
------------

// File: rtl/rr_grant_scheduler_pkg.sv
// rr_grant_scheduler_pkg: shared state encoding and sizing helper for the round-robin scheduler
package rr_grant_scheduler_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} stateT;
    function automatic int numReq(input int selWidth);
        return 1 << selWidth;
    endfunction
endpackage

// File: rtl/rr_grant_scheduler_if.sv
// rr_grant_scheduler_if: request/grant bundle between requesters (master) and the scheduler (slave)
interface rr_grant_scheduler_if
    import rr_grant_scheduler_pkg::*;
#(parameter int SELECT_WIDTH = 3);
    localparam int N = numReq(SELECT_WIDTH);
    logic [N-1:0]            req;
    logic                    done;
    logic [N-1:0]            grant;
    logic [SELECT_WIDTH-1:0] grant_idx;
    logic                    grant_valid;
    logic                    timeout;
    modport master(output req, done, input grant, grant_idx, grant_valid, timeout);
    modport slave(input req, done, output grant, grant_idx, grant_valid, timeout);
endinterface

// File: rtl/nbit_demux.sv
// nbit_demux: routes DeMuxIn onto the single output line selected by DeMuxSel
module nbit_demux #(parameter int SEL_WIDTH = 3) (
    input  logic                      DeMuxIn,
    input  logic [SEL_WIDTH-1:0]      DeMuxSel,
    output logic [(2**SEL_WIDTH)-1:0] DeMuxOut
);
    assign DeMuxOut = DeMuxIn ? ((2**SEL_WIDTH)'(1) << DeMuxSel) : '0;
endmodule

// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler: round-robin owner selection with done/implicit/timeout release
// and back-to-back handover; grant is a decode of the registered owner index.
module rr_grant_scheduler
    import rr_grant_scheduler_pkg::*;
#(
    parameter int SELECT_WIDTH = 3,
    parameter int MAX_HOLD     = 16,
    parameter int HOLD_WIDTH   = 5
) (
    input logic clk,
    input logic reset,
    rr_grant_scheduler_if.slave bus
);
    localparam int N = numReq(SELECT_WIDTH);
    stateT                   state;
    logic [SELECT_WIDTH-1:0] ptr;
    logic [SELECT_WIDTH-1:0] grantIdx;
    logic [HOLD_WIDTH-1:0]   holdCnt;
    logic                    grantValid;
    logic                    timeoutQ;
    logic                    owning;
    logic                    expire;
    logic                    releaseNow;
    logic [SELECT_WIDTH-1:0] searchPtr;
    logic [N-1:0]            searchReq;
    logic                    found;
    logic [SELECT_WIDTH-1:0] foundIdx;
    logic [SELECT_WIDTH-1:0] cand;
    assign owning     = state == ST_GRANT;
    assign expire     = owning && !bus.done && bus.req[grantIdx] && MAX_HOLD != 0
                        && holdCnt == HOLD_WIDTH'(MAX_HOLD - 1);
    assign releaseNow = owning && (bus.done || !bus.req[grantIdx] || expire);
    // on release the search starts just past the owner, which is itself masked out
    assign searchPtr  = owning ? grantIdx + SELECT_WIDTH'(1) : ptr;
    assign searchReq  = owning ? bus.req & ~(N'(1) << grantIdx) : bus.req;
    always_comb begin
        found    = 1'b0;
        foundIdx = '0;
        cand     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = searchPtr + SELECT_WIDTH'(i);
            if (searchReq[cand]) begin
                found    = 1'b1;
                foundIdx = cand;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            grantIdx   <= '0;
            holdCnt    <= '0;
            grantValid <= 1'b0;
            timeoutQ   <= 1'b0;
        end else begin
            timeoutQ <= expire;
            if (!owning || releaseNow) begin
                if (releaseNow) ptr <= grantIdx + SELECT_WIDTH'(1);
                if (found) grantIdx <= foundIdx;
                state      <= found ? ST_GRANT : ST_IDLE;
                grantValid <= found;
                holdCnt    <= '0;
            end else begin
                holdCnt <= holdCnt + HOLD_WIDTH'(1);
            end
        end
    end
    assign bus.grant_idx   = grantIdx;
    assign bus.grant_valid = grantValid;
    assign bus.timeout     = timeoutQ;
    nbit_demux #(.SEL_WIDTH(SELECT_WIDTH)) grantDecode (
        .DeMuxIn (grantValid),
        .DeMuxSel(grantIdx),
        .DeMuxOut(bus.grant)
    );
endmodule

// File: tb/tb_rr_grant_scheduler.sv
// tb_rr_grant_scheduler: vector table through a scoreboard queue, plus a timed hold-expiry sequence
module tb_rr_grant_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    rr_grant_scheduler_if #(.SELECT_WIDTH(3)) bus();
    rr_grant_scheduler #(.SELECT_WIDTH(3), .MAX_HOLD(4), .HOLD_WIDTH(5)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic [7:0] expGrant;
        logic       expValid;
        logic [2:0] expIdx;
        logic       expTo;
    } vecT;
    vecT tbl[$];
    vecT sb[$];
    int  nChecks = 0;
    int  nFails  = 0;
    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, k, act, exp);
        end
    endtask
    function automatic vecT v(input logic r, input logic [7:0] q, input logic d,
                              input logic [7:0] g, input logic vl, input logic [2:0] ix, input logic t);
        vecT x;
        x.rst = r; x.req = q; x.done = d; x.expGrant = g; x.expValid = vl; x.expIdx = ix; x.expTo = t;
        return x;
    endfunction
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        vecT e;
        int held;
        bus.req  = '0;
        bus.done = 1'b0;
        // reset with all requesting, then grant from ptr=0
        tbl.push_back(v(1, 8'hFF, 0, 8'h00, 0, 0, 0));
        tbl.push_back(v(1, 8'hFF, 0, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'hFF, 0, 8'h01, 1, 0, 0));
        // rotation 1..7,0 with no bubble
        for (int i = 1; i <= 8; i++)
            tbl.push_back(v(0, 8'hFF, 1, 8'(1 << (i % 8)), 1, 3'(i % 8), 0));
        for (int i = 1; i <= 6; i++)
            tbl.push_back(v(0, 8'hFF, 1, 8'(1 << i), 1, 3'(i), 0));
        // skip and wrap
        tbl.push_back(v(0, 8'h05, 1, 8'h01, 1, 0, 0));
        tbl.push_back(v(0, 8'h05, 1, 8'h04, 1, 2, 0));
        tbl.push_back(v(0, 8'h05, 1, 8'h01, 1, 0, 0));
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 0, 0, 0));
        // hold expiry: requester 1 held four cycles, no preemption by 3
        for (int i = 0; i < 4; i++) tbl.push_back(v(0, 8'h0A, 0, 8'h02, 1, 1, 0));
        tbl.push_back(v(0, 8'h0A, 0, 8'h08, 1, 3, 1));
        tbl.push_back(v(0, 8'h0A, 0, 8'h08, 1, 3, 0));
        // implicit release, sole-requester bubble
        tbl.push_back(v(0, 8'h10, 0, 8'h10, 1, 4, 0));
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h10, 0, 8'h10, 1, 4, 0));
        tbl.push_back(v(0, 8'h10, 1, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h10, 0, 8'h10, 1, 4, 0));
        // reset while 3 owns with counter=2
        tbl.push_back(v(0, 8'h08, 0, 8'h08, 1, 3, 0));
        tbl.push_back(v(0, 8'h08, 0, 8'h08, 1, 3, 0));
        tbl.push_back(v(0, 8'h08, 0, 8'h08, 1, 3, 0));
        tbl.push_back(v(1, 8'h08, 0, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h88, 0, 8'h08, 1, 3, 0));
        // done while idle is ignored
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 1, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h04, 1, 8'h04, 1, 2, 0));
        @(negedge clk);
        for (int k = 0; k < tbl.size(); k++) begin
            reset    = tbl[k].rst;
            bus.req  = tbl[k].req;
            bus.done = tbl[k].done;
            sb.push_back(tbl[k]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check("grant", k, 32'(bus.grant), 32'(e.expGrant));
            check("grant_valid", k, 32'(bus.grant_valid), 32'(e.expValid));
            check("timeout", k, 32'(bus.timeout), 32'(e.expTo));
            if (e.expValid) check("grant_idx", k, 32'(bus.grant_idx), 32'(e.expIdx));
        end
        reset    = 1'b1;
        bus.req  = 8'h0A;
        bus.done = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        held  = 0;
        for (int c = 0; c < 20 && !bus.timeout; c++) begin
            @(posedge clk);
            #1;
            if (!bus.timeout && bus.grant == 8'h02) held++;
        end
        check("expiry_seen", 100, 32'(bus.timeout), 32'(1));
        check("expiry_hold_cycles", 100, 32'(held), 32'(4));
        check("expiry_next_owner", 100, 32'(bus.grant), 32'(8'h08));
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
